mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
- REQ-001 Parameter: TIMEOUT_CYCLES, default 64, number of WAIT cycles before a transaction is aborted; used only with MEM_ARB_TIMEOUT_EN.
- REQ-002 clk  input  1  single clock; all state updates on posedge.
- REQ-003 reset  input  1  asynchronous, active-low reset.
- REQ-004 fetchReq  input  1  fetch port request, level, read-only.
- REQ-005 fetchAddr  input  32  fetch address.
- REQ-006 fetchDone  output  1  one-cycle completion pulse.
- REQ-007 fetchData  output  32  read data, valid while fetchDone=1.
- REQ-008 dataReq  input  1  data port request, level.
- REQ-009 dataWe  input  1  1=write, 0=read.
- REQ-010 dataAddr  input  32  data address.
- REQ-011 dataWrData  input  32  write data.
- REQ-012 dataDone  output  1  one-cycle completion pulse.
- REQ-013 dataRdData  output  32  read data, valid while dataDone=1.
- REQ-014 addrVirtual  input  1  address mode for the granted transaction.
- REQ-015 execMode  input  1  execution mode for the granted transaction.
- REQ-016 busErr  output  1  qualifies fetchDone/dataDone; 1=aborted transaction.
- REQ-017 mcRamAddress  output  32  memory controller address.
- REQ-018 mcRamIn  output  32  memory controller write data.
- REQ-019 mcRequest  output  1  memory controller request pulse.
- REQ-020 mcWriteEnable  output  1  memory controller write enable.
- REQ-021 mcAddrVirtual  output  1  memory controller address mode.
- REQ-022 mcExecMode  output  1  memory controller execution mode.
- REQ-023 RamOutput  input  32  memory controller read data.
- REQ-024 mcStatus  input  2  memory controller status; 2 = transaction complete.

Function
- REQ-025 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
- REQ-026 In IDLE with any request present, the arbiter SHALL grant one port, latch address, write data, write enable (fetch forces 0), addrVirtual and execMode into the mc* registers, and go to ISSUE.
- REQ-027 When both ports request in the same cycle, the grant SHALL go to the port not granted last (round-robin); a lone requester SHALL always be granted.
- REQ-028 In ISSUE, mcRequest SHALL be 1 for exactly one cycle; the state SHALL then go to WAIT.
- REQ-029 mcRamAddress, mcRamIn, mcWriteEnable, mcAddrVirtual and mcExecMode SHALL stay stable from ISSUE until leaving WAIT.
- REQ-030 In WAIT, mcStatus==2 SHALL capture RamOutput into the granted port's read-data register and move to DONE; other mcStatus values SHALL keep WAIT.
- REQ-031 In DONE, exactly the granted port's Done SHALL be 1 for one cycle; the state SHALL then return to IDLE.
- REQ-032 Minimum latency SHALL be: request sampled at edge N, mcRequest high after edge N+1, mcStatus==2 sampled at edge M, Done high after edge M+1.
- REQ-033 Read data SHALL hold its value after Done until the next completion on the same port.
- REQ-034 A requester deasserting its request after grant SHALL NOT cancel the transaction; Done SHALL still pulse.
- REQ-035 A request held through DONE SHALL be treated as a new request in the following IDLE cycle.
- REQ-036 Write transactions SHALL still update dataRdData with RamOutput.

Reset
- REQ-037 While reset=0, the state SHALL be IDLE and all outputs 0, including mcRequest, both Done, busErr and all data/address registers.
- REQ-038 On reset the last-granted marker SHALL be the data port, so fetch wins the first tie.
- REQ-039 Reset asserted in any state SHALL abandon the transaction with no Done pulse.

Configuration
- REQ-040 MEM_ARB_TIMEOUT_EN defined: a WAIT-cycle counter SHALL run; if it reaches TIMEOUT_CYCLES without mcStatus==2, the FSM SHALL go to DONE with busErr=1 alongside the Done pulse and read data 32'hDEADBEEF.
- REQ-041 MEM_ARB_TIMEOUT_EN undefined: no counter SHALL exist, busErr SHALL be constant 0, and WAIT SHALL persist indefinitely.

Verification
- REQ-042 Data write: addr 0, data 291, dataWe=1 -> one mcRequest pulse with mcWriteEnable=1 and mcRamIn=291, then dataDone pulse with busErr=0.
- REQ-043 Fetch of addr 0 after that write -> mcWriteEnable=0, then fetchDone with fetchData=291.
- REQ-044 fetchReq and dataReq held together from reset -> grants alternate fetch, data, fetch, data, with one Done per transaction and no overlap.
- REQ-045 reset pulled low during WAIT -> all outputs 0 immediately, no Done; the next request proceeds normally.
- REQ-046 MEM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and mcStatus held at 1 -> Done plus busErr=1 and data 32'hDEADBEEF after 16 WAIT cycles; without the macro, no Done within 200 cycles.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: the fetch port, the data port, the
// per-transaction mode bits and the memory-controller side.
//
// Handshake: fetchReq/dataReq are levels sampled only while the arbiter is
// idle; once a port is granted its request may drop without cancelling the
// transaction. Each granted transaction ends with exactly one one-cycle
// fetchDone/dataDone pulse, qualified by busErr, and the read data is valid
// in that cycle and held afterwards. Towards the memory controller,
// mcRequest is a one-cycle pulse. The mc* address/data/mode lines stay
// stable until mcStatus==2 reports completion.
interface mem_port_arbiter_if;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        fetchDone;
  logic [31:0] fetchData;
  logic        dataReq;
  logic        dataWe;
  logic [31:0] dataAddr;
  logic [31:0] dataWrData;
  logic        dataDone;
  logic [31:0] dataRdData;
  logic        addrVirtual;
  logic        execMode;
  logic        busErr;
  logic [31:0] mcRamAddress;
  logic [31:0] mcRamIn;
  logic        mcRequest;
  logic        mcWriteEnable;
  logic        mcAddrVirtual;
  logic        mcExecMode;
  logic [31:0] RamOutput;
  logic [1:0]  mcStatus;

  // Arbiter view: serves both requesters and drives the memory controller.
  modport slave (
    input  fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWrData,
           addrVirtual, execMode, RamOutput, mcStatus,
    output fetchDone, fetchData, dataDone, dataRdData, busErr,
           mcRamAddress, mcRamIn, mcRequest, mcWriteEnable,
           mcAddrVirtual, mcExecMode
  );

  // Environment view: the requesters plus the memory controller.
  modport master (
    output fetchReq, fetchAddr, dataReq, dataWe, dataAddr, dataWrData,
           addrVirtual, execMode, RamOutput, mcStatus,
    input  fetchDone, fetchData, dataDone, dataRdData, busErr,
           mcRamAddress, mcRamIn, mcRequest, mcWriteEnable,
           mcAddrVirtual, mcExecMode
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) round-robin arbiter in front of a single memory
// controller. One transaction at a time: IDLE -> ISSUE -> WAIT -> DONE.
// Optional feature macro MEM_ARB_TIMEOUT_EN: aborts a transaction that waits
// TIMEOUT_CYCLES cycles without completion, returning busErr=1 and
// 32'hDEADBEEF. Without the macro, WAIT lasts until completion and busErr=0.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus,
  output logic [1:0]         dbgState
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic        grantData;   // port of the current/last grant, 1 = data port
  logic        anyReq;
  logic        pickData;
  logic        respOk;
  logic        timeoutHit;
  logic        finishWait;
  logic [31:0] capData;

  logic        mcRequestQ;
  logic        mcWeQ;
  logic        mcVirtQ;
  logic        mcExecQ;
  logic [31:0] mcAddrQ;
  logic [31:0] mcInQ;
  logic        fetchDoneQ;
  logic        dataDoneQ;
  logic [31:0] fetchDataQ;
  logic [31:0] dataRdDataQ;

  assign anyReq     = bus.fetchReq | bus.dataReq;
  // On a tie the data port wins only if fetch was granted last.
  assign pickData   = bus.dataReq & (~bus.fetchReq | ~grantData);
  assign respOk     = (bus.mcStatus == 2'd2);
  assign finishWait = (state == WAIT) & (respOk | timeoutHit);
  // A real completion takes precedence over a timeout in the same cycle.
  assign capData    = respOk ? bus.RamOutput : 32'hDEADBEEF;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] waitCnt;
  logic             abortQ;
  logic             busErrQ;

  assign timeoutHit = (state == WAIT) & ~respOk &
                      (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count consecutive WAIT cycles; remember an abort until its DONE pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt <= '0;
      abortQ  <= 1'b0;
      busErrQ <= 1'b0;
    end else begin
      waitCnt <= (state == WAIT) ? waitCnt + CNT_W'(1) : '0;
      if (timeoutHit) begin
        abortQ <= 1'b1;
      end else if (state == DONE) begin
        abortQ <= 1'b0;
      end
      busErrQ <= (state == DONE) & abortQ;
    end
  end

  assign bus.busErr = busErrQ;
`else
  assign timeoutHit = 1'b0;
  assign bus.busErr = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (anyReq) stateNext = ISSUE;
      ISSUE:   stateNext = WAIT;
      WAIT:    if (respOk || timeoutHit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Grant latch: the winner's command is frozen until the next grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grantData <= 1'b1;
      mcAddrQ   <= '0;
      mcInQ     <= '0;
      mcWeQ     <= 1'b0;
      mcVirtQ   <= 1'b0;
      mcExecQ   <= 1'b0;
    end else if (state == IDLE && anyReq) begin
      grantData <= pickData;
      mcAddrQ   <= pickData ? bus.dataAddr : bus.fetchAddr;
      mcInQ     <= pickData ? bus.dataWrData : 32'h0;
      mcWeQ     <= pickData & bus.dataWe;
      mcVirtQ   <= bus.addrVirtual;
      mcExecQ   <= bus.execMode;
    end
  end

  // Controller request pulse, read-data capture and completion pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcRequestQ  <= 1'b0;
      fetchDoneQ  <= 1'b0;
      dataDoneQ   <= 1'b0;
      fetchDataQ  <= '0;
      dataRdDataQ <= '0;
    end else begin
      mcRequestQ <= (state == ISSUE);
      fetchDoneQ <= (state == DONE) & ~grantData;
      dataDoneQ  <= (state == DONE) & grantData;
      if (finishWait) begin
        if (grantData) begin
          dataRdDataQ <= capData;
        end else begin
          fetchDataQ <= capData;
        end
      end
    end
  end

  assign bus.mcRequest     = mcRequestQ;
  assign bus.mcRamAddress  = mcAddrQ;
  assign bus.mcRamIn       = mcInQ;
  assign bus.mcWriteEnable = mcWeQ;
  assign bus.mcAddrVirtual = mcVirtQ;
  assign bus.mcExecMode    = mcExecQ;
  assign bus.fetchDone     = fetchDoneQ;
  assign bus.dataDone      = dataDoneQ;
  assign bus.fetchData     = fetchDataQ;
  assign bus.dataRdData    = dataRdDataQ;
  assign dbgState          = state;

endmodule
